// File: rtl/match_scorer_if.sv
// Signal bundle between the round win/lose stage and the match scorer.
// Start, Win and Lose are sampled levels. The scorer's outputs are status levels, except RoundRst, which is a 1-cycle pulse.
interface match_scorer_if #(
    parameter int CNT_W = 3
);
    logic             Start;
    logic             Win;
    logic             Lose;
    logic             RoundRst;
    logic [CNT_W-1:0] WinCount;
    logic [CNT_W-1:0] LoseCount;
    logic             ShowResult;
    logic             MatchOver;
    logic             MatchWon;

    modport master (
        output Start, Win, Lose,
        input  RoundRst, WinCount, LoseCount, ShowResult, MatchOver, MatchWon
    );

    modport slave (
        input  Start, Win, Lose,
        output RoundRst, WinCount, LoseCount, ShowResult, MatchOver, MatchWon
    );
endinterface

// File: rtl/match_scorer.sv
// First-to-WIN_TARGET match scorer. It holds each round result for HOLD_CYCLES cycles.
// It then waits for Win/Lose to drop, and pulses RoundRst to restart the round counters.
module match_scorer #(
    parameter int WIN_TARGET  = 3,
    parameter int CNT_W       = 3,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    match_scorer_if.slave bus,
    output logic [2:0] State
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] PLAY     = 3'd2;
    localparam logic [2:0] SHOW     = 3'd3;
    localparam logic [2:0] WAIT_REL = 3'd4;
    localparam logic [2:0] OVER     = 3'd5;

    localparam int               TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TARGET    = CNT_W'(WIN_TARGET);
    localparam logic [TW-1:0]    HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] lose_cnt;
    logic [TW-1:0]    timer;
    logic             round_rst;
    logic             win_r;
    logic             lose_r;
    logic             any_prev;
    logic             round_evt;
    logic             target_hit;

    // The edge detector samples in every state, so a level that is still high when PLAY is re-entered is not counted twice.
    assign round_evt  = (win_r | lose_r) & ~any_prev;
    assign target_hit = (win_cnt == TARGET) || (lose_cnt == TARGET);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            win_r    <= 1'b0;
            lose_r   <= 1'b0;
            any_prev <= 1'b0;
        end else begin
            win_r    <= bus.Win;
            lose_r   <= bus.Lose;
            any_prev <= win_r | lose_r;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            win_cnt   <= '0;
            lose_cnt  <= '0;
            timer     <= '0;
            round_rst <= 1'b0;
        end else begin
            round_rst <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (bus.Start) begin
                        state     <= START;
                        win_cnt   <= '0;
                        lose_cnt  <= '0;
                        round_rst <= 1'b1;
                    end
                end
                START: state <= PLAY;
                PLAY: begin
                    if (round_evt) begin
                        // A simultaneous Win and Lose counts as a loss.
                        if (win_r && !lose_r) win_cnt  <= win_cnt + 1'b1;
                        else                  lose_cnt <= lose_cnt + 1'b1;
                        timer <= HOLD_LOAD;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (timer == '0) state <= WAIT_REL;
                    else             timer <= timer - 1'b1;
                end
                WAIT_REL: begin
                    if (!bus.Win && !bus.Lose) begin
                        if (target_hit) begin
                            state <= OVER;
                        end else begin
                            state     <= PLAY;
                            round_rst <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.RoundRst   = round_rst;
    assign bus.WinCount   = win_cnt;
    assign bus.LoseCount  = lose_cnt;
    assign bus.ShowResult = (state == SHOW) || (state == WAIT_REL);
    assign bus.MatchOver  = (state == OVER);
    assign bus.MatchWon   = (state == OVER) && (win_cnt == TARGET);
    assign State          = state;
endmodule

// File: tb/tb_match_scorer.sv
// Directed bench for match_scorer with WIN_TARGET=3, CNT_W=3, HOLD_CYCLES=4.
// It covers the start pulse, win/lose/tie rounds, both match outcomes, restart, and an asynchronous reset applied in the middle of a match.
module tb_match_scorer;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    logic       Clock;
    logic       Reset;
    logic [2:0] state;
    int         n_cmp  = 0;
    int         n_fail = 0;

    match_scorer_if #(.CNT_W(3)) bus ();

    match_scorer #(.WIN_TARGET(3), .CNT_W(3), .HOLD_CYCLES(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave),
        .State (state)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic rr,
                           input logic [2:0] wc, input logic [2:0] lc,
                           input logic sr, input logic mo, input logic mw);
        chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
        chk({tag, ".rr"},    {7'd0, bus.RoundRst}, {7'd0, rr});
        chk({tag, ".win"},   {5'd0, bus.WinCount}, {5'd0, wc});
        chk({tag, ".lose"},  {5'd0, bus.LoseCount}, {5'd0, lc});
        chk({tag, ".show"},  {7'd0, bus.ShowResult}, {7'd0, sr});
        chk({tag, ".over"},  {7'd0, bus.MatchOver}, {7'd0, mo});
        chk({tag, ".won"},   {7'd0, bus.MatchWon}, {7'd0, mw});
    endtask

    // A full round: raise the levels, let the event register and SHOW run out (6 edges), drop the levels, then take the release edge.
    task automatic do_round(input logic w, input logic l);
        bus.Win  = w;
        bus.Lose = l;
        tick(6);
        bus.Win  = 1'b0;
        bus.Lose = 1'b0;
        tick(1);
    endtask

    task automatic start_pulse;
        bus.Start = 1'b1;
        tick(1);
        bus.Start = 1'b0;
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Win   = 1'b0;
        bus.Lose  = 1'b0;
        Reset     = 1'b0;
        tick(2);
        chk_all("reset", S_IDLE, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        tick(2);
        chk_all("idle", S_IDLE, 0, 0, 0, 0, 0, 0);

        // 1: the start pulse gives a single RoundRst cycle
        start_pulse();
        chk_all("start", S_START, 1, 0, 0, 0, 0, 0);
        tick(1);
        chk_all("play0", S_PLAY, 0, 0, 0, 0, 0, 0);

        // 2: Win is held for 10 cycles; Start is ignored in PLAY
        bus.Win   = 1'b1;
        bus.Start = 1'b1;
        tick(1);
        bus.Start = 1'b0;
        chk_all("win_reg", S_PLAY, 0, 0, 0, 0, 0, 0);
        tick(1);
        chk_all("win_cnt", S_SHOW, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_all("show", S_SHOW, 0, 1, 0, 1, 0, 0);
        end
        tick(1);
        chk_all("wait", S_WAIT, 0, 1, 0, 1, 0, 0);
        tick(4);
        chk_all("wait_held", S_WAIT, 0, 1, 0, 1, 0, 0);
        bus.Win = 1'b0;
        tick(1);
        chk_all("release", S_PLAY, 1, 1, 0, 0, 0, 0);
        tick(1);
        chk_all("rr_end", S_PLAY, 0, 1, 0, 0, 0, 0);
        tick(3);
        chk_all("no_reevt", S_PLAY, 0, 1, 0, 0, 0, 0);

        // 3: Win and Lose together count as a loss
        do_round(1'b1, 1'b1);
        chk_all("tie", S_PLAY, 1, 1, 1, 0, 0, 0);

        // 4: W, then W, reaches 3-1 and the player wins
        tick(1);
        do_round(1'b1, 1'b0);
        chk_all("w2", S_PLAY, 1, 2, 1, 0, 0, 0);
        tick(1);
        do_round(1'b1, 1'b0);
        chk_all("match_won", S_OVER, 0, 3, 1, 0, 1, 1);
        bus.Win = 1'b1;
        tick(3);
        bus.Win = 1'b0;
        tick(2);
        chk_all("over_ign", S_OVER, 0, 3, 1, 0, 1, 1);

        // 5: a new match, then L, L, L
        start_pulse();
        chk_all("restart", S_START, 1, 0, 0, 0, 0, 0);
        tick(1);
        do_round(1'b0, 1'b1);
        chk_all("l1", S_PLAY, 1, 0, 1, 0, 0, 0);
        tick(1);
        do_round(1'b0, 1'b1);
        chk_all("l2", S_PLAY, 1, 0, 2, 0, 0, 0);
        tick(1);
        do_round(1'b0, 1'b1);
        chk_all("match_lost", S_OVER, 0, 0, 3, 0, 1, 0);
        start_pulse();
        chk_all("restart2", S_START, 1, 0, 0, 0, 0, 0);
        tick(1);
        chk_all("play2", S_PLAY, 0, 0, 0, 0, 0, 0);

        // 6: asynchronous reset while SHOW is active with WinCount=2
        do_round(1'b1, 1'b0);
        tick(1);
        bus.Win = 1'b1;
        tick(3);
        chk_all("pre_rst", S_SHOW, 0, 2, 0, 1, 0, 0);
        #2;
        Reset = 1'b0;
        #1;
        chk_all("async_rst", S_IDLE, 0, 0, 0, 0, 0, 0);
        bus.Win = 1'b0;
        tick(1);
        Reset = 1'b1;
        tick(2);
        chk_all("post_rst", S_IDLE, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
